// File: rtl/udp_frag_scheduler.sv
// UDP TX fragmentation engine: buffers a payload stream and re-emits it as
// fragments of at most mss beats, separated by ifg idle cycles.
module udp_frag_scheduler #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_W      = 32,
  parameter int AF_MARGIN  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CNT_W-1:0]    cmd_size,
  input  logic [CNT_W-1:0]    cmd_mss,
  input  logic [CNT_W-1:0]    cmd_ifg,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tuser,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic [15:0]         udp_length,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    frag_cnt
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = AW + 1;
  localparam int ENT_W  = DATA_W + KEEP_W + 1;
  localparam logic [OCC_W-1:0] AF_LEVEL = OCC_W'(FIFO_DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] BYTES    = CNT_W'(KEEP_W);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, mss_q, ifg_q;
  logic [CNT_W-1:0] frag_len_q, frag_beat_q, gap_cnt_q, frag_cnt_q;
  logic [15:0]      udp_len_q;
  logic             done_q;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic [ENT_W-1:0] head;

  logic             fifo_empty, wr_en, rd_en, frag_end, last_xfer;
  logic [CNT_W-1:0] cmd_mss_eff, next_len_cmd, next_len_job;

  assign fifo_empty = (occ_q == '0);
  assign head       = mem[rd_ptr_q];
  assign frag_end   = (frag_beat_q == frag_len_q - CNT_W'(1));

  // Fragment length is min(mss, remaining); mss of 0 behaves as 1.
  assign cmd_mss_eff  = (cmd_mss == '0) ? CNT_W'(1) : cmd_mss;
  assign next_len_cmd = (cmd_mss_eff < cmd_size) ? cmd_mss_eff : cmd_size;
  assign next_len_job = (mss_q < rem_q) ? mss_q : rem_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    m_axis_tvalid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid && cmd_size != '0) state_d = SEND;
      end
      SEND: begin
        m_axis_tvalid = !fifo_empty;
        if (m_axis_tvalid && m_axis_tready && frag_end) begin
          if (rem_q == '0)       state_d = FLUSH;
          else if (ifg_q != '0)  state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == CNT_W'(1)) state_d = SEND;
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign s_axis_tready = busy && (occ_q < AF_LEVEL);
  assign wr_en         = s_axis_tvalid && s_axis_tready;
  assign rd_en         = m_axis_tvalid && m_axis_tready;
  assign last_xfer     = rd_en && frag_end;

  assign m_axis_tlast  = m_axis_tvalid && frag_end;
  assign m_axis_tdata  = m_axis_tvalid ? head[DATA_W-1:0] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? head[DATA_W +: KEEP_W] : '0;
  assign m_axis_tuser  = m_axis_tvalid && head[ENT_W-1];
  assign udp_length    = udp_len_q;
  assign done          = done_q;
  assign frag_cnt      = frag_cnt_q;

  // Job and fragment bookkeeping; the next fragment is loaded on the tlast beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q       <= '0;
      mss_q       <= '0;
      ifg_q       <= '0;
      frag_len_q  <= '0;
      frag_beat_q <= '0;
      gap_cnt_q   <= '0;
      frag_cnt_q  <= '0;
      udp_len_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == FLUSH);
      if (state_q == IDLE && cmd_valid) begin
        mss_q       <= cmd_mss_eff;
        ifg_q       <= cmd_ifg;
        frag_cnt_q  <= '0;
        rem_q       <= cmd_size - next_len_cmd;
        frag_len_q  <= next_len_cmd;
        frag_beat_q <= '0;
        udp_len_q   <= 16'(next_len_cmd * BYTES);
      end
      if (rd_en) begin
        if (last_xfer) begin
          frag_cnt_q  <= frag_cnt_q + CNT_W'(1);
          frag_beat_q <= '0;
          if (rem_q != '0) begin
            rem_q      <= rem_q - next_len_job;
            frag_len_q <= next_len_job;
            udp_len_q  <= 16'(next_len_job * BYTES);
            gap_cnt_q  <= ifg_q;
          end
        end else begin
          frag_beat_q <= frag_beat_q + CNT_W'(1);
        end
      end
      if (state_q == GAP) gap_cnt_q <= gap_cnt_q - CNT_W'(1);
    end
  end

  // FIFO pointers; FLUSH discards whatever input exceeded the job.
  always_ff @(posedge clk) begin
    if (rst || state_q == FLUSH) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q <= occ_q + OCC_W'(wr_en) - OCC_W'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {s_axis_tuser, s_axis_tkeep, s_axis_tdata};
  end

endmodule
